dm_bus_arbiter: RTL and testbench

- Shares the single data-memory/peripheral port between two masters: m0 is the CPU load/store path, m1 is a secondary master such as a DMA or boot loader.
- Selects one access per cycle, forwards it combinationally to the peripheral bus, and acknowledges the winner in the same cycle.
- The CPU stalls via `cpu_stall` while it loses arbitration.
- Round-robin fairness, with an optional bounded lock (burst) for m1.

---
 rtl/dm_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dm_bus_arbiter
//
// Shares the single data-memory / peripheral port between two masters:
//   m0 - CPU load/store path (stalled through cpu_stall while it loses)
//   m1 - secondary master (DMA, boot loader) with an optional bounded lock
//
// One access is selected per cycle and forwarded combinationally to the
// slave port; the winner is acknowledged in the same cycle (zero latency,
// writes commit at the clock edge that ends the ack cycle).
//
// Handshake: a master holds req and payload stable until it sees ack in the
// same cycle; ack means "performed this cycle". Dropping req before ack
// cancels the access, nothing is latched inside the arbiter.
//
// Arbitration:
//   IDLE - a single requester wins; with both requesting the master that
//          did not own the bus last wins (strict alternation).
//   LOCK - entered when m1 is granted with m1_lock set. m1 keeps the bus
//          while it requests, unless m0 is waiting and m1 has already had
//          MAX_BURST beats since the lock started counting.
//
// Optional feature (macro DM_ARB_STATS_EN): grant and stall statistics
// counters. With the macro undefined the stat_* outputs are tied to zero
// and no counter flops exist.
// ---------------------------------------------------------------------------
module dm_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,

    // master 0: CPU load/store path
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [2:0]       m0_op,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_ack,
    output logic [DW-1:0]    m0_rdata,
    output logic             cpu_stall,

    // master 1: secondary master with lock
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [2:0]       m1_op,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    input  logic             m1_lock,
    output logic             m1_ack,
    output logic [DW-1:0]    m1_rdata,

    // slave port
    output logic             s_wr,
    output logic             s_rd,
    output logic [2:0]       s_op,
    output logic [AW-1:0]    s_addr,
    output logic [DW-1:0]    s_wdata,
    input  logic [DW-1:0]    s_rdata,

    // statistics
    output logic [CNT_W-1:0] stat_m0_grants,
    output logic [CNT_W-1:0] stat_m1_grants,
    output logic [CNT_W-1:0] stat_stall_cycles
);

    // Burst counter must be able to hold MAX_BURST itself.
    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]   BURST_ONE = BW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_cnt_nxt;
    logic          last_owner;      // 0 = m0 owned the last grant, 1 = m1
    logic          last_owner_nxt;

    logic          grant0;
    logic          grant1;
    logic          burst_room;

    // m1 may still take a beat while m0 waits only below the burst limit.
    assign burst_room = (burst_cnt < BURST_MAX);

    // -----------------------------------------------------------------------
    // State register: FSM state, burst counter and last owner.
    // Reset puts the last owner on m1 so m0 wins the first tie.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Winner selection. Nothing is granted while reset is asserted so no
    // access reaches the slave in a reset cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state == LOCK) begin
                if (m1_req && (burst_room || !m0_req)) begin
                    grant1 = 1'b1;
                end else if (m0_req) begin
                    grant0 = 1'b1;
                end
            end else if (m0_req && m1_req) begin
                // tie in IDLE: the master that did not own the bus last wins
                if (last_owner) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: owner tracking, lock entry/exit and burst counting.
    // The burst counter only advances while m0 is actually waiting, so an
    // uncontended lock never uses up m1's burst allowance.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        burst_cnt_nxt  = burst_cnt;
        last_owner_nxt = last_owner;

        if (grant0) begin
            last_owner_nxt = 1'b0;
        end else if (grant1) begin
            last_owner_nxt = 1'b1;
        end

        if (state == IDLE) begin
            if (grant1 && m1_lock) begin
                state_nxt     = LOCK;
                burst_cnt_nxt = BURST_ONE;
            end
        end else begin
            if (grant1 && m1_lock) begin
                if (m0_req && burst_room) begin
                    burst_cnt_nxt = burst_cnt + BURST_ONE;
                end
            end else begin
                // m1 released the lock, stopped requesting, or m0 took the
                // beat after the burst limit: back to fair alternation
                state_nxt     = IDLE;
                burst_cnt_nxt = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: forward the winner to the slave and route the slave
    // read data back to the winner only. Idle bus drives zeros.
    // -----------------------------------------------------------------------
    always_comb begin
        m0_ack   = grant0;
        m1_ack   = grant1;
        m0_rdata = '0;
        m1_rdata = '0;
        s_wr     = 1'b0;
        s_rd     = 1'b0;
        s_op     = 3'b000;
        s_addr   = '0;
        s_wdata  = '0;
        if (grant0) begin
            s_wr     = m0_we;
            s_rd     = ~m0_we;
            s_op     = m0_op;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            m0_rdata = s_rdata;
        end else if (grant1) begin
            s_wr     = m1_we;
            s_rd     = ~m1_we;
            s_op     = m1_op;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            m1_rdata = s_rdata;
        end
    end

    // CPU stalls whenever it asks and is not served this cycle.
    assign cpu_stall = m0_req & ~m0_ack;

`ifdef DM_ARB_STATS_EN
    logic [CNT_W-1:0] m0_grants;
    logic [CNT_W-1:0] m1_grants;
    logic [CNT_W-1:0] stall_cycles;

    // Free-running statistics, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_grants    <= '0;
            m1_grants    <= '0;
            stall_cycles <= '0;
        end else begin
            if (m0_ack) begin
                m0_grants <= m0_grants + CNT_W'(1);
            end
            if (m1_ack) begin
                m1_grants <= m1_grants + CNT_W'(1);
            end
            if (cpu_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    assign stat_m0_grants    = m0_grants;
    assign stat_m1_grants    = m1_grants;
    assign stat_stall_cycles = stall_cycles;
`else
    assign stat_m0_grants    = '0;
    assign stat_m1_grants    = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_bus_arbiter
//
// Directed scenarios with literal expectations followed by a randomized run.
// A behavioural arbiter model checks every DUT output on every falling edge.
// Build with +define+DM_ARB_STATS_EN to exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_dm_bus_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic             m0_req, m0_we;
    logic [2:0]       m0_op;
    logic [AW-1:0]    m0_addr;
    logic [DW-1:0]    m0_wdata;
    logic             m0_ack;
    logic [DW-1:0]    m0_rdata;
    logic             cpu_stall;
    logic             m1_req, m1_we, m1_lock;
    logic [2:0]       m1_op;
    logic [AW-1:0]    m1_addr;
    logic [DW-1:0]    m1_wdata;
    logic             m1_ack;
    logic [DW-1:0]    m1_rdata;
    logic             s_wr, s_rd;
    logic [2:0]       s_op;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [DW-1:0]    s_rdata;
    logic [CNT_W-1:0] stat_m0_grants, stat_m1_grants, stat_stall_cycles;

    dm_bus_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .cpu_stall(cpu_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_ack(m1_ack),
        .m1_rdata(m1_rdata),
        .s_wr(s_wr), .s_rd(s_rd), .s_op(s_op), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata),
        .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
        .stat_stall_cycles(stat_stall_cycles)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // lock_on: m1 currently holds the bus by lock
    // beats:   m1 beats counted toward its burst allowance
    // last_m1: most recent grant went to m1
    bit               md_lock_on = 1'b0;
    int               md_beats   = 0;
    bit               md_last_m1 = 1'b1;
    logic [CNT_W-1:0] md_s0 = '0, md_s1 = '0, md_ss = '0;
    int               win;             // 0 none, 1 m0, 2 m1
    logic             e_stall;

    always @(negedge clk) begin
        // who must win this cycle
        win = 0;
        if (rst) begin
            win = 0;
        end else if (md_lock_on) begin
            if (m1_req && (md_beats < MAX_BURST || !m0_req)) win = 2;
            else if (m0_req) win = 1;
        end else if (m0_req && m1_req) begin
            win = md_last_m1 ? 1 : 2;
        end else if (m0_req) begin
            win = 1;
        end else if (m1_req) begin
            win = 2;
        end
        e_stall = m0_req && (win != 1);

        chk("m0_ack", m0_ack, win == 1);
        chk("m1_ack", m1_ack, win == 2);
        chk("cpu_stall", cpu_stall, e_stall);
        chk("m0_rdata", m0_rdata, (win == 1) ? s_rdata : '0);
        chk("m1_rdata", m1_rdata, (win == 2) ? s_rdata : '0);
        chk("s_wr", s_wr, (win == 1) ? m0_we : (win == 2) ? m1_we : 1'b0);
        chk("s_rd", s_rd, (win == 1) ? !m0_we : (win == 2) ? !m1_we : 1'b0);
        if (rst || win != 0) begin
            chk("s_addr", s_addr, (win == 1) ? m0_addr : (win == 2) ? m1_addr : '0);
            chk("s_wdata", s_wdata, (win == 1) ? m0_wdata : (win == 2) ? m1_wdata : '0);
            chk("s_op", s_op, (win == 1) ? m0_op : (win == 2) ? m1_op : 3'b000);
        end
        chk("stat_m0", stat_m0_grants, md_s0);
        chk("stat_m1", stat_m1_grants, md_s1);
        chk("stat_stall", stat_stall_cycles, md_ss);

        // advance the model to the state after the coming clock edge
        if (rst) begin
            md_lock_on = 1'b0;
            md_beats   = 0;
            md_last_m1 = 1'b1;
            md_s0 = '0; md_s1 = '0; md_ss = '0;
        end else begin
            if (win != 0) md_last_m1 = (win == 2);
            if (!md_lock_on) begin
                if (win == 2 && m1_lock) begin
                    md_lock_on = 1'b1;
                    md_beats   = 1;
                end
            end else if (win == 2 && m1_lock) begin
                if (m0_req && md_beats < MAX_BURST) md_beats++;
            end else begin
                md_lock_on = 1'b0;
                md_beats   = 0;
            end
`ifdef DM_ARB_STATS_EN
            if (win == 1) md_s0 = md_s0 + 1'b1;
            if (win == 2) md_s1 = md_s1 + 1'b1;
            if (e_stall)  md_ss = md_ss + 1'b1;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_op = 3'd0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_op = 3'd0; m1_addr = '0; m1_wdata = '0;
        m1_lock = 0; s_rdata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        next_cycle();

        // reset cycle with both requesting: nothing granted
        m0_req = 1; m1_req = 1;
        sample();
        chk("rst_no_ack0", m0_ack, 1'b0);
        chk("rst_no_ack1", m1_ack, 1'b0);
        chk("rst_no_rd", s_rd, 1'b0);
        next_cycle();

        // m0-only read right after reset
        rst = 0; m1_req = 0;
        m0_we = 0; m0_addr = 32'h100; s_rdata = 32'hDEADBEEF;
        sample();
        chk("rd_ack", m0_ack, 1'b1);
        chk("rd_data", m0_rdata, 32'hDEADBEEF);
        chk("rd_stall", cpu_stall, 1'b0);
        chk("rd_s_rd", s_rd, 1'b1);
        next_cycle();

        // alternation: both request for 6 cycles after a fresh reset
        rst = 1; m0_req = 1; m1_req = 1;
        next_cycle();
        rst = 0;
        m1_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("alt_m0", m0_ack, (i % 2) == 0);
            chk("alt_m1", m1_ack, (i % 2) == 1);
            chk("alt_stall", cpu_stall, (i % 2) == 1);
            next_cycle();
        end
        m0_req = 0; m1_req = 0;
        sample();
`ifdef DM_ARB_STATS_EN
        chk("alt_stat_m0", stat_m0_grants, 16'd3);
        chk("alt_stat_m1", stat_m1_grants, 16'd3);
        chk("alt_stat_stall", stat_stall_cycles, 16'd3);
`else
        chk("alt_stat_m0", stat_m0_grants, 16'd0);
        chk("alt_stat_m1", stat_m1_grants, 16'd0);
        chk("alt_stat_stall", stat_stall_cycles, 16'd0);
`endif
        next_cycle();

        // one m0 beat so m1 wins the next tie
        m0_req = 1;
        next_cycle();

        // m1 locked write burst against a waiting m0
        m1_req = 1; m1_lock = 1; m1_we = 1; m1_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            m1_addr = 32'h200 + 32'(4 * i);
            sample();
            if (i < 4) begin
                chk("burst_m1_ack", m1_ack, 1'b1);
                chk("burst_wr", s_wr, 1'b1);
                chk("burst_addr", s_addr, 32'h200 + 32'(4 * i));
            end else begin
                chk("burst_end_m0", m0_ack, 1'b1);
            end
            next_cycle();
        end
        // back in IDLE: tie goes to m1 again
        m1_lock = 0;
        sample();
        chk("post_burst_m1", m1_ack, 1'b1);
        next_cycle();

        // uncontended lock for 10 cycles, then m0 joins
        m0_req = 0; m1_lock = 1;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("solo_lock_m1", m1_ack, 1'b1);
            next_cycle();
        end
        m0_req = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("join_m0", m0_ack, i == 3);
            next_cycle();
        end

        // reset in the middle of a lock
        m0_req = 0;
        repeat (2) next_cycle();
        rst = 1; m0_req = 1;
        sample();
        chk("midlock_rst_m0", m0_ack, 1'b0);
        chk("midlock_rst_m1", m1_ack, 1'b0);
        next_cycle();
        rst = 0;
        sample();
        chk("after_rst_m0", m0_ack, 1'b1);
        next_cycle();
        sample();
        chk("after_rst_m1", m1_ack, 1'b1);
        next_cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m1_lock  = ($urandom_range(0, 2) != 0);
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m0_op    = 3'($urandom_range(0, 7));
            m1_op    = 3'($urandom_range(0, 7));
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            s_rdata  = $urandom;
            next_cycle();
        end

        idle_inputs();
        rst = 0;
        sample();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
